// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_MULT_EN to build the multiplier for opcode 0101; otherwise it reports an error.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_ctrl,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_MULT = 4'b0101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] opA_q, opA_d, opB_q, opB_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             grantAny;
  logic             grantId;
  logic [WIDTH-1:0] aluResult;
  logic             aluErr;

  // lastGrant_q == 1 means req1 won last time, so a tie goes to req0.
  always_comb begin
    grantAny = req0_valid | req1_valid;
    grantId  = req1_valid & (~req0_valid | ~lastGrant_q);
  end

  always_comb begin
    aluResult = '0;
    aluErr    = 1'b0;
    case (ctrl_q)
      OP_ADD: aluResult = opA_q + opB_q;
      OP_SUB: aluResult = opA_q - opB_q;
      OP_AND: aluResult = opA_q & opB_q;
      OP_OR:  aluResult = opA_q | opB_q;
`ifdef ALU_ARBITER_MULT_EN
      OP_MULT: aluResult = opA_q * opB_q;
`else
      OP_MULT: aluErr = 1'b1;
`endif
      default: aluErr = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    ctrl_d      = ctrl_q;
    id_d        = id_q;
    result_d    = result_q;
    err_d       = err_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grantAny) begin
          req0_ready  = ~grantId & ~reset;
          req1_ready  = grantId & ~reset;
          opA_d       = grantId ? req1_a : req0_a;
          opB_d       = grantId ? req1_b : req0_b;
          ctrl_d      = grantId ? req1_ctrl : req0_ctrl;
          id_d        = grantId;
          lastGrant_d = grantId;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        result_d = aluResult;
        err_d    = aluErr;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      opA_q       <= '0;
      opB_q       <= '0;
      ctrl_q      <= '0;
      id_q        <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      ctrl_q      <= ctrl_d;
      id_q        <= id_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted requests push model results, handshakes push observed ones.
// Honors ALU_ARBITER_MULT_EN the same way the design does.
module tb_alu_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        err;
    int          cyc;
  } rec_t;

`ifdef ALU_ARBITER_MULT_EN
  localparam logic        MULT_ERR = 1'b0;
  localparam logic [31:0] MULT_3X5 = 32'd15;
`else
  localparam logic        MULT_ERR = 1'b1;
  localparam logic [31:0] MULT_3X5 = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  rec_t expQ[$];
  rec_t obsQ[$];

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU; returns {err, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'd1: model = {1'b0, a + b};
      4'd2: model = {1'b0, a - b};
      4'd3: model = {1'b0, a & b};
      4'd4: model = {1'b0, a | b};
`ifdef ALU_ARBITER_MULT_EN
      4'd5: model = {1'b0, a * b};
`endif
      default: model = {1'b1, 32'd0};
    endcase
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (!reset) begin
      if (req0_ready) begin
        r.id = 1'b0; {r.err, r.res} = model(req0_a, req0_b, req0_ctrl); r.cyc = cyc;
        expQ.push_back(r);
      end
      if (req1_ready) begin
        r.id = 1'b1; {r.err, r.res} = model(req1_a, req1_b, req1_ctrl); r.cyc = cyc;
        expQ.push_back(r);
      end
      if (rsp_valid && rsp_ready) begin
        r.id = rsp_id; r.res = rsp_result; r.err = rsp_err; r.cyc = cyc;
        obsQ.push_back(r);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 4'd1;
    req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 4'd1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ((req0_ready | req1_ready) !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_result !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp: got valid=%b id=%b err=%b res=%0h expected all zero", rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single();
    rec_t e, o;
    bit   acc = 0;
    @(posedge clk); #1;
    req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 4'd1; req0_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); acc = req0_ready; end
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int i = 0; i < 20 && obsQ.size() < 1; i++) @(negedge clk);
    #1;
    vectors++;
    if (!acc || expQ.size() != 1 || obsQ.size() != 1) begin
      miscompares++; $display("[TB] FAIL single_timeout: got exp=%0d obs=%0d expected 1 each", expQ.size(), obsQ.size());
      expQ.delete(); obsQ.delete();
      return;
    end
    e = expQ.pop_front(); o = obsQ.pop_front();
    vectors++;
    if (o.res !== 32'd12) begin miscompares++; $display("[TB] FAIL single_result: got %0d expected 12", o.res); end
    vectors++;
    if (o.id !== 1'b0 || e.id !== 1'b0) begin miscompares++; $display("[TB] FAIL single_id: got rsp %b grant %b expected 0", o.id, e.id); end
    vectors++;
    if (o.err !== 1'b0) begin miscompares++; $display("[TB] FAIL single_err: got %b expected 0", o.err); end
    vectors++;
    if (o.cyc - e.cyc != 2) begin miscompares++; $display("[TB] FAIL single_latency: got %0d expected 2", o.cyc - e.cyc); end
  endtask

  task automatic test_contention();
    rec_t e, o;
    int   nAcc = 0;
    int   prevCyc = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    expQ.delete(); obsQ.delete();
    req0_a = 32'd10;   req0_b = 32'd3;    req0_ctrl = 4'd2;
    req1_a = 32'hF0;   req1_b = 32'h3C;   req1_ctrl = 4'd3;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 40 && nAcc < 4; i++) begin
      @(negedge clk);
      if (req0_ready | req1_ready) nAcc++;
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 40 && obsQ.size() < 4; i++) @(negedge clk);
    #1;
    vectors++;
    if (expQ.size() != 4 || obsQ.size() != 4) begin
      miscompares++; $display("[TB] FAIL contention_count: got exp=%0d obs=%0d expected 4 each", expQ.size(), obsQ.size());
      expQ.delete(); obsQ.delete();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      logic        expId;
      logic [31:0] expRes;
      expId  = k[0];
      expRes = k[0] ? 32'h30 : 32'd7;
      e = expQ.pop_front(); o = obsQ.pop_front();
      vectors++;
      if (e.id !== expId || o.id !== expId) begin
        miscompares++; $display("[TB] FAIL contention_id[%0d]: got grant %b rsp %b expected %b", k, e.id, o.id, expId);
      end
      vectors++;
      if (o.res !== expRes || o.err !== 1'b0) begin
        miscompares++; $display("[TB] FAIL contention_res[%0d]: got %0h err %b expected %0h err 0", k, o.res, o.err, expRes);
      end
      if (k > 0) begin
        vectors++;
        if (e.cyc - prevCyc != 3) begin
          miscompares++; $display("[TB] FAIL contention_spacing[%0d]: got %0d expected 3", k, e.cyc - prevCyc);
        end
      end
      prevCyc = e.cyc;
    end
  endtask

  task automatic test_backpressure();
    rec_t o;
    bit   acc = 0;
    bit   seen = 0;
    @(posedge clk); #1;
    req1_a = 32'd100; req1_b = 32'd23; req1_ctrl = 4'd1;
    req1_valid = 1'b1; req0_valid = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); acc = req1_ready; end
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rsp_valid; end
    vectors++;
    if (!acc || !seen) begin
      miscompares++; $display("[TB] FAIL bp_timeout: got acc=%b valid=%b expected 1 1", acc, seen);
    end
    for (int j = 0; j < 5; j++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd123 || rsp_id !== 1'b1) begin
        miscompares++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b res=%0d id=%b expected 1 123 1", j, rsp_valid, rsp_result, rsp_id);
      end
      vectors++;
      if ((req0_ready | req1_ready) !== 1'b0) begin
        miscompares++; $display("[TB] FAIL bp_ready[%0d]: got %b%b expected 00", j, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_idle: got valid=%b expected 0", rsp_valid); end
    vectors++;
    if (obsQ.size() != 1 || expQ.size() != 1) begin
      miscompares++; $display("[TB] FAIL bp_handshakes: got obs=%0d exp=%0d expected 1 each", obsQ.size(), expQ.size());
    end else begin
      o = obsQ.pop_front(); void'(expQ.pop_front());
      vectors++;
      if (o.res !== 32'd123 || o.id !== 1'b1) begin
        miscompares++; $display("[TB] FAIL bp_result: got %0d id %b expected 123 id 1", o.res, o.id);
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_wrap_error();
    logic [31:0] ta[6] = '{32'hFFFFFFFF, 32'd0, 32'h1234, 32'h10000, 32'hF0F0, 32'd3};
    logic [31:0] tbv[6] = '{32'd1, 32'd1, 32'd5, 32'h10000, 32'h0F00, 32'd5};
    logic [3:0]  tc[6] = '{4'd1, 4'd2, 4'hF, 4'd5, 4'd4, 4'd5};
    logic [31:0] tr[6] = '{32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFF0, MULT_3X5};
    logic        te[6] = '{1'b0, 1'b0, 1'b1, MULT_ERR, 1'b0, MULT_ERR};
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rec_t o;
      bit   acc = 0;
      logic who;
      who = i[0];
      @(posedge clk); #1;
      if (who) begin req1_a = ta[i]; req1_b = tbv[i]; req1_ctrl = tc[i]; req1_valid = 1'b1; end
      else     begin req0_a = ta[i]; req0_b = tbv[i]; req0_ctrl = tc[i]; req0_valid = 1'b1; end
      for (int k = 0; k < 20 && !acc; k++) begin @(negedge clk); acc = req0_ready | req1_ready; end
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 20 && obsQ.size() < 1; k++) @(negedge clk);
      #1;
      vectors++;
      if (obsQ.size() != 1) begin
        miscompares++; $display("[TB] FAIL wrap_timeout[%0d]: got %0d responses expected 1", i, obsQ.size());
      end else begin
        o = obsQ.pop_front();
        vectors++;
        if (o.res !== tr[i] || o.err !== te[i] || o.id !== who) begin
          miscompares++;
          $display("[TB] FAIL wrap_op[%0d]: got res=%0h err=%b id=%b expected res=%0h err=%b id=%b", i, o.res, o.err, o.id, tr[i], te[i], who);
        end
      end
      expQ.delete(); obsQ.delete();
    end
  endtask

  task automatic test_reset_exec();
    rec_t o;
    bit   acc = 0;
    @(posedge clk); #1;
    req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 4'd1; req0_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); acc = req0_ready; end
    @(posedge clk); #1 req0_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstexec_async: got valid=%b res=%0h id=%b err=%b expected all zero", rsp_valid, rsp_result, rsp_id, rsp_err);
    end
    @(posedge clk); #1 reset = 1'b0;
    expQ.delete(); obsQ.delete();
    repeat (6) @(negedge clk);
    #1;
    vectors++;
    if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL rstexec_ghost: got %0d responses expected 0", obsQ.size()); end
    @(posedge clk); #1;
    req0_a = 32'hA0; req0_b = 32'h0B; req0_ctrl = 4'd4;
    req1_a = 32'd8;  req1_b = 32'd2;  req1_ctrl = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstexec_tie: got %b%b expected 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 20 && obsQ.size() < 1; k++) @(negedge clk);
    #1;
    vectors++;
    if (obsQ.size() != 1) begin
      miscompares++; $display("[TB] FAIL rstexec_resp: got %0d responses expected 1", obsQ.size());
    end else begin
      o = obsQ.pop_front();
      vectors++;
      if (o.res !== 32'hAB || o.id !== 1'b0 || o.err !== 1'b0) begin
        miscompares++; $display("[TB] FAIL rstexec_result: got %0h id %b err %b expected ab id 0 err 0", o.res, o.id, o.err);
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap_error();
    test_reset_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-007 SHALL have ports req0_ctrl / req1_ctrl  input  4  opcode: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 MULT.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_id  output  1  index of requester owning the result.
REQ-011 SHALL have port rsp_result  output  WIDTH  operation result.
REQ-012 SHALL have port rsp_err  output  1  opcode unsupported.

Function
REQ-013 SHALL share one ALU datapath between two requesters, one operation in flight at a time.
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any reqN_valid, SHALL assert reqN_ready for exactly the granted requester (combinational, same cycle), capture its operands, opcode and id, go to EXEC; else stay IDLE.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; single valid, grant it regardless of history.
REQ-017 After reset, last-grant pointer SHALL be 1 (req0 wins first tie).
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP.
REQ-019 EXEC: SHALL compute the captured operation and register rsp_result/rsp_err, go to RESP (one cycle).
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH; MULT SHALL return low WIDTH bits of product.
REQ-021 Opcode outside REQ-007 list SHALL give rsp_result 0, rsp_err 1.
REQ-022 RESP: rsp_valid SHALL be 1; rsp_result, rsp_id, rsp_err SHALL hold stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-023 Latency: accept at edge N -> rsp_valid high after edge N+2; back-to-back accept no earlier than cycle after response handshake (max one op per 3 cycles).
REQ-024 Requester deasserting valid before acceptance SHALL lose no state; request ignored.
REQ-025 rsp_valid SHALL be 0 outside RESP.

Reset
REQ-026 reset high SHALL immediately force state IDLE, rsp_valid 0, rsp_result 0, rsp_id 0, rsp_err 0, last-grant 1, independent of clk.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation; no response produced.
REQ-028 reqN_ready SHALL be 0 while reset asserted.

Configuration
REQ-029 Macro ALU_ARBITER_MULT_EN defined: opcode 0101 SHALL compute MULT per REQ-020, rsp_err 0.
REQ-030 ALU_ARBITER_MULT_EN undefined: no multiplier instantiated; opcode 0101 SHALL give rsp_result 0, rsp_err 1, same latency.

Verification
REQ-031 Single op: req0 ADD a=5 b=7, rsp_ready=1 -> accept cycle 0, rsp_valid cycle 2, result 12, rsp_id 0, rsp_err 0.
REQ-032 Contention: both valid continuously (req0 SUB 10-3, req1 AND F0&3C) -> grants 0,1,0,1; results 7, 0x30 alternate with matching rsp_id.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> result/id stable, both reqN_ready 0, release completes one handshake then IDLE.
REQ-034 Wrap/error: ADD FFFFFFFF+1 -> 0; opcode 1111 -> result 0, rsp_err 1; MULT 0x10000*0x10000 -> 0 with macro, err 1 without.
REQ-035 Reset in EXEC: assert reset mid-op asynchronously -> rsp_valid 0 at once, no response after release, next tie granted to req0.
